xy_pattern_gen: RTL

Stimulus generator for the two-input FSM practice blocks. It drives a programmed sequence of (x, y) symbol pairs into a detector FSM one symbol per clock, with an optional repeat count and idle gap between repeats. It closes the loop so detector blocks can be exercised in hardware or self-checking benches, not only from hand-written initial blocks. It sits upstream of the detector and shares its clock and reset.

---
 rtl/xy_pattern_gen_if.sv | 26 ++
 rtl/xy_pattern_gen.sv | 129 ++++++++++++
 2 files changed

// File: rtl/xy_pattern_gen_if.sv
// Stimulus bus between the pattern generator and its controller:
// run controls and patterns in, symbol stream and status out.
interface xy_pattern_gen_if #(
  parameter int LEN = 4
);
  logic           start;
  logic           abort;
  logic [LEN-1:0] xpat;
  logic [LEN-1:0] ypat;
  logic [3:0]     rep;
  logic           x;
  logic           y;
  logic           valid;
  logic           busy;
  logic           done;

  modport master (
    output start, abort, xpat, ypat, rep,
    input  x, y, valid, busy, done
  );

  modport slave (
    input  start, abort, xpat, ypat, rep,
    output x, y, valid, busy, done
  );
endinterface

// File: rtl/xy_pattern_gen.sv
// Plays a latched (x, y) symbol pattern into a detector one symbol per clock,
// repeated rep times with GAP idle cycles between repeats.
module xy_pattern_gen #(
  parameter int LEN = 4,
  parameter int GAP = 2
) (
  input logic              clk,
  input logic              rst,
  xy_pattern_gen_if.slave  bus
);
  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_DONE} state_t;

  localparam logic [2:0] IDX_LAST = 3'(LEN - 1);
  localparam logic [2:0] GAP_LAST = 3'(GAP - 1);

  state_t         state_q, state_d;
  logic [2:0]     idx_q, idx_d;
  logic [3:0]     rep_q, rep_d;
  logic [2:0]     gap_q, gap_d;
  logic [LEN-1:0] xpat_q, xpat_d;
  logic [LEN-1:0] ypat_q, ypat_d;
  logic           x_q, x_d, y_q, y_d;
  logic           valid_q, valid_d, busy_q, busy_d, done_q, done_d;
  logic [7:0]     xw, yw;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rep_d   = rep_q;
    gap_d   = gap_q;
    xpat_d  = xpat_q;
    ypat_d  = ypat_q;
    x_d     = 1'b0;
    y_d     = 1'b0;
    valid_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    xw      = 8'd0;
    yw      = 8'd0;

    if (bus.abort) begin
      // Abort beats every transition, including a start seen in IDLE.
      state_d = S_IDLE;
      idx_d   = 3'd0;
      rep_d   = 4'd0;
      gap_d   = 3'd0;
    end else begin
      case (state_q)
        S_IDLE: if (bus.start) begin
          xpat_d  = bus.xpat;
          ypat_d  = bus.ypat;
          rep_d   = (bus.rep == 4'd0) ? 4'd1 : bus.rep;
          idx_d   = 3'd0;
          state_d = S_SEND;
        end
        S_SEND: if (idx_q == IDX_LAST) begin
          idx_d = 3'd0;
          if (rep_q > 4'd1) begin
            rep_d   = rep_q - 4'd1;
            gap_d   = 3'd0;
            state_d = (GAP == 0) ? S_SEND : S_GAP;
          end else begin
            rep_d   = 4'd0;
            state_d = S_DONE;
          end
        end else begin
          idx_d = idx_q + 3'd1;
        end
        S_GAP: if (gap_q == GAP_LAST) begin
          gap_d   = 3'd0;
          idx_d   = 3'd0;
          state_d = S_SEND;
        end else begin
          gap_d = gap_q + 3'd1;
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Outputs are registered, so they are decoded from the next state.
    xw = 8'(xpat_d);
    yw = 8'(ypat_d);
    case (state_d)
      S_SEND: begin
        x_d     = xw[idx_d];
        y_d     = yw[idx_d];
        valid_d = 1'b1;
        busy_d  = 1'b1;
      end
      S_GAP:   busy_d = 1'b1;
      S_DONE:  done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= 3'd0;
      rep_q   <= 4'd0;
      gap_q   <= 3'd0;
      xpat_q  <= '0;
      ypat_q  <= '0;
      x_q     <= 1'b0;
      y_q     <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rep_q   <= rep_d;
      gap_q   <= gap_d;
      xpat_q  <= xpat_d;
      ypat_q  <= ypat_d;
      x_q     <= x_d;
      y_q     <= y_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.x     = x_q;
  assign bus.y     = y_q;
  assign bus.valid = valid_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
endmodule
